// File: rtl/multi_timer.sv
// Multi-channel timer: NUM_CH independent up-counters sharing one prescaler tick,
// each with one-shot/periodic mode, expiry pulse and sticky pending flag.
module multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic               cfg_periodic,
  input  logic               cfg_enable,
  input  logic [NUM_CH-1:0]  irq_clr,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [CNT_W-1:0]   rd_count,
  output logic [NUM_CH-1:0]  running,
  output logic [NUM_CH-1:0]  timer_fire,
  output logic [NUM_CH-1:0]  irq_pending,
  output logic               irq
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] run_q,  run_d;
  logic [NUM_CH-1:0] fire_q, fire_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  always_comb begin
    // >= rather than == so a prescale lowered below the running count still ticks
    tick    = (presc_q >= prescale);
    presc_d = tick ? '0 : presc_q + 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      mode_d[i]   = mode_q[i];
      run_d[i]    = run_q[i];
      fire_d[i]   = 1'b0;
      pend_d[i]   = pend_q[i] & ~irq_clr[i];
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        // A write overrides a coincident expiry; pending is left to irq_clr alone
        count_d[i]  = '0;
        period_d[i] = cfg_period;
        mode_d[i]   = cfg_periodic;
        run_d[i]    = cfg_enable && (cfg_period != '0);
      end else if (run_q[i] && tick) begin
        if (count_q[i] == period_q[i] - CNT_W'(1)) begin
          count_d[i] = '0;
          fire_d[i]  = 1'b1;
          pend_d[i]  = 1'b1;
          run_d[i]   = mode_q[i];
        end else begin
          count_d[i] = count_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      mode_q  <= '0;
      run_q   <= '0;
      fire_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      fire_q  <= fire_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // Unmapped channel selects fall through every comparison and read as zero
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_count = count_q[i];
    end
  end

  assign running     = run_q;
  assign timer_fire  = fire_q;
  assign irq_pending = pend_q;
  assign irq         = |pend_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: expected expiry cycles are queued when a
// channel is configured and consumed as timer_fire pulses appear.
module tb_multi_timer;
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 16;
  localparam int PRESC_W = 4;
  localparam int CH_W    = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic               cfg_we = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic               cfg_periodic = 1'b0;
  logic               cfg_enable = 1'b0;
  logic [NUM_CH-1:0]  irq_clr = '0;
  logic [CH_W-1:0]    rd_ch = '0;
  logic [CNT_W-1:0]   rd_count;
  logic [NUM_CH-1:0]  running;
  logic [NUM_CH-1:0]  timer_fire;
  logic [NUM_CH-1:0]  irq_pending;
  logic               irq;

  multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .cfg_enable(cfg_enable),
    .irq_clr(irq_clr), .rd_ch(rd_ch), .rd_count(rd_count), .running(running),
    .timer_fire(timer_fire), .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lo_q[$];
  int hi_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] per,
                           input logic periodic, input logic en, output int wedge);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_periodic = periodic; cfg_enable = en;
    step();
    cfg_we = 1'b0;
    wedge = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0; step(); step();
    checks++; if (running !== 5'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (timer_fire !== 5'b0) begin errors++; $display("FAIL reset_fire: got %b want 0", timer_fire); end
    checks++; if (irq_pending !== 5'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", irq_pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rd_count); end
    rst = 1'b1; step();
  endtask

  task automatic test_periodic();
    int w, e;
    prescale = 0;
    cfg_write(3'd0, 16'd5, 1'b1, 1'b1, w);
    for (int k = 1; k <= 4; k++) exp_q.push_back(w + 5 * k);
    for (int n = 0; n < 22; n++) begin
      step();
      if (timer_fire[0]) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL periodic_extra: fire at cyc %0d, none expected", cyc); end
        else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin errors++; $display("FAIL periodic_time: got cyc %0d want %0d", cyc, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_missing: %0d fires not seen want 0", exp_q.size()); end
    exp_q.delete();
    checks++; if (irq_pending[0] !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL periodic_pend: got %b/%b want 1/1", irq_pending[0], irq); end
    rd_ch = 3'd0; #1;
    checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL periodic_count: got %0d want 2", rd_count); end
    cfg_write(3'd0, 16'd5, 1'b1, 1'b0, w);
    checks++; if (running[0] !== 1'b0 || rd_count !== 16'd0) begin errors++; $display("FAIL periodic_stop: got run %b cnt %0d want 0 0", running[0], rd_count); end
    irq_clr = '1; step(); irq_clr = '0;
    checks++; if (irq_pending !== 5'b0) begin errors++; $display("FAIL periodic_clr: got %b want 0", irq_pending); end
  endtask

  task automatic test_oneshot_presc();
    int w, w2, lo, hi, last2;
    prescale = 3;
    cfg_write(3'd2, 16'd2, 1'b1, 1'b1, w2);
    cfg_write(3'd1, 16'd2, 1'b0, 1'b1, w);
    lo_q.push_back(w + 5); hi_q.push_back(w + 8);
    last2 = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (timer_fire[1]) begin
        checks++;
        if (lo_q.size() == 0) begin errors++; $display("FAIL oneshot_extra: fire at cyc %0d, none expected", cyc); end
        else begin
          lo = lo_q.pop_front(); hi = hi_q.pop_front();
          if (cyc < lo || cyc > hi) begin errors++; $display("FAIL oneshot_time: got cyc %0d want %0d..%0d", cyc, lo, hi); end
        end
      end
      if (timer_fire[2]) begin
        if (last2 >= 0) begin
          checks++;
          if (cyc - last2 !== 8) begin errors++; $display("FAIL presc_spacing: got %0d want 8", cyc - last2); end
        end
        last2 = cyc;
      end
    end
    checks++; if (lo_q.size() != 0) begin errors++; $display("FAIL oneshot_missing: %0d fires not seen want 0", lo_q.size()); end
    lo_q.delete(); hi_q.delete();
    rd_ch = 3'd1; #1;
    checks++; if (running[1] !== 1'b0 || rd_count !== 16'd0) begin errors++; $display("FAIL oneshot_after: got run %b cnt %0d want 0 0", running[1], rd_count); end
    checks++; if (running[2] !== 1'b1) begin errors++; $display("FAIL presc_running: got %b want 1", running[2]); end
    cfg_write(3'd2, 16'd2, 1'b1, 1'b0, w);
    irq_clr = '1; step(); irq_clr = '0;
  endtask

  task automatic test_period_edge();
    int w, e, nf;
    prescale = 0;
    cfg_write(3'd2, 16'd0, 1'b1, 1'b1, w);
    checks++; if (running[2] !== 1'b0) begin errors++; $display("FAIL zero_running: got %b want 0", running[2]); end
    nf = 0;
    for (int n = 0; n < 100; n++) begin step(); if (timer_fire[2]) nf++; end
    checks++; if (nf !== 0 || irq_pending[2] !== 1'b0) begin errors++; $display("FAIL zero_fire: got %0d fires pend %b want 0 0", nf, irq_pending[2]); end
    cfg_write(3'd3, 16'd1, 1'b1, 1'b1, w);
    for (int k = 1; k <= 10; k++) exp_q.push_back(w + k);
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if (!timer_fire[3]) begin errors++; $display("FAIL one_fire: no fire at cyc %0d want fire", cyc); end
      else if (exp_q.size() == 0) begin errors++; $display("FAIL one_extra: fire at cyc %0d, none expected", cyc); end
      else begin
        e = exp_q.pop_front();
        if (cyc !== e) begin errors++; $display("FAIL one_time: got cyc %0d want %0d", cyc, e); end
      end
    end
    exp_q.delete();
    cfg_write(3'd3, 16'd1, 1'b1, 1'b0, w);
    irq_clr = '1; step(); irq_clr = '0;
  endtask

  task automatic test_irq_clr_race();
    int w;
    prescale = 0;
    cfg_write(3'd0, 16'd3, 1'b1, 1'b1, w);
    step(); step();
    irq_clr = 5'b00001; step();
    checks++; if (timer_fire[0] !== 1'b1) begin errors++; $display("FAIL race_fire: got %b want 1", timer_fire[0]); end
    checks++; if (irq_pending[0] !== 1'b1) begin errors++; $display("FAIL race_setwins: got %b want 1", irq_pending[0]); end
    step();
    checks++; if (irq_pending[0] !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL race_clear: got %b/%b want 0/0", irq_pending[0], irq); end
    irq_clr = '0;
    cfg_write(3'd0, 16'd3, 1'b1, 1'b0, w);
  endtask

  task automatic test_cfg_race();
    int w, w2, w3, e;
    prescale = 0;
    cfg_write(3'd3, 16'd4, 1'b1, 1'b1, w);
    step(); step(); step();
    cfg_write(3'd3, 16'd4, 1'b1, 1'b1, w2);
    rd_ch = 3'd3; #1;
    checks++; if (timer_fire[3] !== 1'b0 || irq_pending[3] !== 1'b0) begin errors++; $display("FAIL cfgwin_fire: got fire %b pend %b want 0 0", timer_fire[3], irq_pending[3]); end
    checks++; if (running[3] !== 1'b1 || rd_count !== 16'd0) begin errors++; $display("FAIL cfgwin_load: got run %b cnt %0d want 1 0", running[3], rd_count); end
    exp_q.push_back(w2 + 4);
    exp_q.push_back(w2 + 8);
    for (int n = 0; n < 4; n++) begin
      step();
      if (timer_fire[3]) begin
        checks++; e = exp_q.pop_front();
        if (cyc !== e) begin errors++; $display("FAIL cfgwin_time: got cyc %0d want %0d", cyc, e); end
      end
    end
    cfg_write(3'd5, 16'd1, 1'b0, 1'b1, w3);
    checks++; if (running !== 5'b01000) begin errors++; $display("FAIL badch_running: got %b want 01000", running); end
    checks++; if (irq_pending !== 5'b01000) begin errors++; $display("FAIL badch_pend: got %b want 01000", irq_pending); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL badch_count: got %0d want 1", rd_count); end
    rd_ch = 3'd5; #1;
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL rd_oob5: got %0d want 0", rd_count); end
    rd_ch = 3'd7; #1;
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL rd_oob7: got %0d want 0", rd_count); end
    for (int n = 0; n < 3; n++) begin
      step();
      if (timer_fire[3]) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL badch_extra: fire at cyc %0d, none expected", cyc); end
        else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin errors++; $display("FAIL badch_time: got cyc %0d want %0d", cyc, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cfgwin_missing: %0d fires not seen want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int w, nf;
    cfg_write(3'd0, 16'd7, 1'b1, 1'b1, w);
    step(); step();
    rst = 1'b0;
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd3; cfg_periodic = 1'b1; cfg_enable = 1'b1;
    step();
    cfg_we = 1'b0;
    rd_ch = 3'd3; #1;
    checks++; if (running !== 5'b0 || timer_fire !== 5'b0) begin errors++; $display("FAIL rstmid_run: got run %b fire %b want 0 0", running, timer_fire); end
    checks++; if (irq_pending !== 5'b0 || irq !== 1'b0) begin errors++; $display("FAIL rstmid_pend: got %b/%b want 0/0", irq_pending, irq); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", rd_count); end
    rst = 1'b1;
    nf = 0;
    for (int n = 0; n < 20; n++) begin step(); if (timer_fire != 0) nf++; end
    checks++; if (nf !== 0 || running !== 5'b0) begin errors++; $display("FAIL rstmid_idle: got %0d fires run %b want 0 0", nf, running); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot_presc();
    test_period_edge();
    test_irq_clr_race();
    test_cfg_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of each channel counter and period.
REQ-003 SHALL have parameter PRESC_W, default 8: width of the shared prescaler.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 resets at posedge clk).
REQ-006 SHALL have port prescale  input  PRESC_W  tick divider; one tick every prescale+1 cycles.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe, one channel per cycle.
REQ-008 SHALL have port cfg_ch  input  CH_W  target channel of the write, CH_W = max(1, clog2(NUM_CH)).
REQ-009 SHALL have port cfg_period  input  CNT_W  period in ticks.
REQ-010 SHALL have port cfg_periodic  input  1  1 = auto-reload, 0 = one-shot.
REQ-011 SHALL have port cfg_enable  input  1  1 = start channel, 0 = stop channel.
REQ-012 SHALL have port irq_clr  input  NUM_CH  per-channel pending clear mask.
REQ-013 SHALL have port rd_ch  input  CH_W  channel selected for count readback.
REQ-014 SHALL have port rd_count  output  CNT_W  combinational count of rd_ch; 0 if rd_ch >= NUM_CH.
REQ-015 SHALL have port running  output  NUM_CH  per-channel running flag, registered.
REQ-016 SHALL have port timer_fire  output  NUM_CH  per-channel one-cycle expiry pulse, registered.
REQ-017 SHALL have port irq_pending  output  NUM_CH  per-channel sticky expiry flag, registered.
REQ-018 SHALL have port irq  output  1  combinational OR of irq_pending.

Function
REQ-019 Prescaler SHALL be a free-running counter presc_cnt: at a posedge where presc_cnt >= prescale it loads 0 and tick=1 for that edge; otherwise it increments and tick=0.
REQ-020 prescale==0 SHALL give tick on every cycle; lowering prescale below presc_cnt SHALL produce a tick on the next edge, never a lock-up.
REQ-021 cfg_we with cfg_ch < NUM_CH SHALL load count=0, period=cfg_period, mode=cfg_periodic, running=cfg_enable AND (cfg_period != 0).
REQ-022 cfg_we with cfg_ch >= NUM_CH SHALL be ignored; cfg_we SHALL not touch the prescaler or irq_pending.
REQ-023 A running channel at a tick edge with count == period-1 SHALL expire: count<=0, timer_fire<=1 for exactly one cycle, irq_pending<=1.
REQ-024 On expiry a one-shot channel SHALL clear running; a periodic channel SHALL stay running and restart from 0.
REQ-025 A running channel at a tick edge with count < period-1 SHALL increment count by 1; count SHALL never exceed period-1 and never wrap.
REQ-026 Stopped channels and non-tick edges SHALL hold count; timer_fire SHALL be 0 in every cycle not directly following an expiry edge.
REQ-027 period==1 SHALL expire on every tick; period==0 SHALL never start (no expiry, no underflow).
REQ-028 cfg_we to a channel on the same edge as its expiry SHALL win: config loaded, no timer_fire, irq_pending unchanged.
REQ-029 irq_clr[i] SHALL clear irq_pending[i] on the next edge; simultaneous expiry and clear SHALL leave irq_pending[i]=1 (set wins).
REQ-030 With prescale=P and period=N, periodic expiries SHALL be exactly N*(P+1) cycles apart; the first expiry after a write SHALL occur between (N-1)*(P+1)+1 and N*(P+1) cycles after the write edge.
REQ-031 Channels SHALL be fully independent apart from the shared tick.

Reset
REQ-032 rst==0 at posedge clk SHALL clear presc_cnt, every count, period, mode, running, timer_fire and irq_pending to 0; irq therefore reads 0.
REQ-033 Reset SHALL override cfg_we, irq_clr and expiry in the same cycle, including mid-count.

Verification
REQ-034 prescale=0; write ch0 period=5 periodic enable -> timer_fire[0] pulses 5 cycles after write, then every 5 cycles; irq_pending[0]=1 after first pulse.
REQ-035 prescale=3; ch1 period=2 one-shot -> single timer_fire[1] 5..8 cycles after write, running[1]=0 afterwards, count holds 0.
REQ-036 Write ch2 period=0 enable=1 -> running[2]=0, no fire over 100 cycles; period=1 prescale=0 -> fire every cycle.
REQ-037 Expiry of ch0 with irq_clr[0]=1 same edge -> irq_pending[0]=1; irq_clr next cycle alone -> 0, irq=0.
REQ-038 cfg_we to ch3 on its expiry edge -> no timer_fire[3]; cfg_ch=NUM_CH -> no state change in any channel.
REQ-039 rst low mid-count with pending set and cfg_we asserted -> all outputs 0 next cycle, no channel running.
